alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU for the single-cycle RISC-V datapath. Performs add, sub, and, or, multiply, shift-left and signed set-less-than, selected by a 3-bit control code.
- The result is registered on the clock and feeds writeback/branch logic.
- A zero flag is produced alongside the result for branch decisions.

Parameters:
- WIDTH, 32, operand/result width in bits; shift amount is the low log2(WIDTH) bits of b (5 bits at default).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ALUControl  input  3  operation select
- ALUResult  output  WIDTH  registered result
- zero  output  1  high when ALUResult equals 0

Behaviour:
- Reset: rst_n low asynchronously forces ALUResult to 0, hence zero=1. Release is synchronous to the next clk edge. Reset asserted mid-operation discards the pending result.
- Latency: one cycle. Inputs sampled at a rising clk edge appear on ALUResult after that edge and hold until the next edge. No handshake; a new operation every cycle.
- zero is combinational from the registered ALUResult: zero = (ALUResult == 0). It is therefore valid in the same cycle as ALUResult.
- Opcode map:
  - 000 ADD: a + b mod 2^WIDTH, carry discarded.
  - 001 SUB: a - b mod 2^WIDTH, two's complement wrap (e.g. 0 - 1 = FFFFFFFF).
  - 010 AND: a & b.
  - 011 OR: a | b.
  - 100 MUL: low WIDTH bits of the unsigned a*b product; upper half discarded. Signedness is irrelevant for the low half.
  - 101 SLL: a << b[4:0]. Upper bits of b are ignored; shift 0 passes a through; shift 31 keeps only a[0] in the MSB.
  - 110 SLT: 1 if $signed(a) < $signed(b), else 0, zero-extended. Comparison is signed: 80000000 < 00000000 gives 1; equal operands give 0.
  - 111 reserved: result 0 (zero=1).
- No overflow/carry flags are exported.
- X or undefined ALUControl must not latch; default branch yields 0.

Decomposition:
- Shared package alu_pkg holds the localparams for the opcode encodings (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_MUL=3'b100, ALU_SLL=3'b101, ALU_SLT=3'b110) and the WIDTH default. The decoder and controller reuse the same package.
- One sub-module is natural: alu_datapath, the purely combinational operation mux. The top alu adds the result register, async reset and zero flag.

Test Plan:
- Reset: assert rst_n=0 with any inputs -> ALUResult=00000000, zero=1 immediately. Release, then apply ADD 5+4 -> 00000009 after one edge.
- Logic:
  - AND a=00000005 b=00000004 -> 00000004.
  - OR a=00000007 b=00000008 -> 0000000F.
  - AND a=0000000F b=000000F0 -> 0, zero=1.
- Arithmetic:
  - ADD a=5 b=4 -> 00000009.
  - SUB a=9 b=4 -> 00000005.
  - SUB a=4 b=4 -> 0, zero=1.
  - ADD FFFFFFFF+1 -> 0 (wrap), zero=1.
- MUL:
  - a=7 b=5 -> 00000023.
  - a=00010000 b=00010000 -> 00000000 (high half dropped).
- SLL:
  - a=3 b=4 -> 00000030.
  - a=1 b=00000024 -> 00000010 (only b[4:0]=4 used).
  - a=1 b=31 -> 80000000.
- SLT:
  - a=3 b=4 -> 1.
  - a=4 b=3 -> 0.
  - a=FFFFFFFF b=1 -> 1 (signed).
  - a=b -> 0 with zero=1.
  - Opcode 111 -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ==========================================================================
// alu_pkg : opcode encodings and default width shared by the ALU slice
// Revision: 1.0
// ==========================================================================
package alu_pkg;
   localparam int          ALU_WIDTH = 32;

   localparam logic [2:0]  ALU_ADD   = 3'b000;
   localparam logic [2:0]  ALU_SUB   = 3'b001;
   localparam logic [2:0]  ALU_AND   = 3'b010;
   localparam logic [2:0]  ALU_OR    = 3'b011;
   localparam logic [2:0]  ALU_MUL   = 3'b100;
   localparam logic [2:0]  ALU_SLL   = 3'b101;
   localparam logic [2:0]  ALU_SLT   = 3'b110;
endpackage
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ==========================================================================
// alu_datapath : combinational operation select for the ALU
// Revision: 1.0
// ==========================================================================
module alu_datapath
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] result_o
);
   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0]   w_shamt;
   logic             w_lt;
   logic [WIDTH-1:0] w_prod;

   assign w_shamt = b_i[SHW-1:0];
   assign w_lt    = $signed(a_i) < $signed(b_i);
   assign w_prod  = a_i * b_i;

   // Reserved and unknown opcodes fall through to zero so nothing latches.
   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_MUL: result_o = w_prod;
         ALU_SLL: result_o = a_i << w_shamt;
         ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, w_lt};
         default: result_o = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ==========================================================================
// alu : registered 32-bit ALU with combinational zero flag
// Revision: 1.0
// ==========================================================================
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ALUControl,
   output logic [WIDTH-1:0] ALUResult,
   output logic             zero
);
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] result_q;

   alu_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .a_i      (a),
      .b_i      (b),
      .op_i     (ALUControl),
      .result_o (result_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign ALUResult = result_q;
   assign zero      = (result_q == '0);
endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ==========================================================================
// tb_alu : table-driven check of the registered ALU
// Revision: 1.0
// ==========================================================================
module tb_alu;
   import alu_pkg::*;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  ALUControl;
   logic [31:0] ALUResult;
   logic        zero;

   int total = 0;
   int bad   = 0;

   vec_t vecs[20];

   alu #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .ALUResult  (ALUResult),
      .zero       (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] exp);
      logic exp_zero;
      exp_zero = (exp == 32'h0);
      total++;
      if (ALUResult !== exp || zero !== exp_zero) begin
         bad++;
         $display("FAIL %s: got result=%08h zero=%b, want result=%08h zero=%b",
                  name, ALUResult, zero, exp, exp_zero);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
      ALUControl = op;
      a          = va;
      b          = vb;
   endtask

   initial begin
      vecs[0]  = '{"add_5_4",      ALU_ADD, 32'h5,        32'h4,        32'h9};
      vecs[1]  = '{"and_5_4",      ALU_AND, 32'h5,        32'h4,        32'h4};
      vecs[2]  = '{"or_7_8",       ALU_OR,  32'h7,        32'h8,        32'hF};
      vecs[3]  = '{"and_zero",     ALU_AND, 32'hF,        32'hF0,       32'h0};
      vecs[4]  = '{"sub_9_4",      ALU_SUB, 32'h9,        32'h4,        32'h5};
      vecs[5]  = '{"sub_4_4",      ALU_SUB, 32'h4,        32'h4,        32'h0};
      vecs[6]  = '{"sub_0_1",      ALU_SUB, 32'h0,        32'h1,        32'hFFFFFFFF};
      vecs[7]  = '{"add_wrap",     ALU_ADD, 32'hFFFFFFFF, 32'h1,        32'h0};
      vecs[8]  = '{"mul_7_5",      ALU_MUL, 32'h7,        32'h5,        32'h23};
      vecs[9]  = '{"mul_hi_drop",  ALU_MUL, 32'h00010000, 32'h00010000, 32'h0};
      vecs[10] = '{"mul_neg",      ALU_MUL, 32'hFFFFFFFF, 32'h3,        32'hFFFFFFFD};
      vecs[11] = '{"sll_3_4",      ALU_SLL, 32'h3,        32'h4,        32'h30};
      vecs[12] = '{"sll_b_upper",  ALU_SLL, 32'h1,        32'h24,       32'h10};
      vecs[13] = '{"sll_31",       ALU_SLL, 32'h1,        32'd31,       32'h80000000};
      vecs[14] = '{"sll_0",        ALU_SLL, 32'hABCD1234, 32'h20,       32'hABCD1234};
      vecs[15] = '{"slt_3_4",      ALU_SLT, 32'h3,        32'h4,        32'h1};
      vecs[16] = '{"slt_4_3",      ALU_SLT, 32'h4,        32'h3,        32'h0};
      vecs[17] = '{"slt_neg1_1",   ALU_SLT, 32'hFFFFFFFF, 32'h1,        32'h1};
      vecs[18] = '{"slt_eq",       ALU_SLT, 32'h12345678, 32'h12345678, 32'h0};
      vecs[19] = '{"op_111",       3'b111,  32'h5,        32'h3,        32'h0};

      // Reset with live ADD inputs: output must stay cleared across edges.
      rst_n = 1'b0;
      drive(ALU_ADD, 32'h5, 32'h4);
      #2;
      check("reset_immediate", 32'h0);
      @(posedge clk); #1;
      check("reset_held_edge", 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_after_reset", 32'h9);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(vecs[i].op, vecs[i].a, vecs[i].b);
         @(posedge clk); #1;
         check(vecs[i].name, vecs[i].exp);
      end

      // Result holds between edges even when the inputs change.
      @(negedge clk);
      drive(ALU_MUL, 32'h7, 32'h5);
      @(posedge clk); #1;
      check("mul_load", 32'h23);
      drive(ALU_ADD, 32'h1, 32'h1);
      #3;
      check("hold_mid_cycle", 32'h23);

      // Asynchronous reset mid-cycle discards the pending ADD.
      rst_n = 1'b0;
      #1;
      check("async_reset_mid", 32'h0);
      @(posedge clk); #1;
      check("pending_discarded", 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(ALU_OR, 32'h7, 32'h8);
      @(posedge clk); #1;
      check("resume_after_reset", 32'hF);

      // Back-to-back operations, one per cycle.
      @(negedge clk);
      drive(ALU_SLT, 32'h80000000, 32'h0);
      @(posedge clk); #1;
      check("slt_min_vs_0", 32'h1);
      drive(ALU_SUB, 32'h0, 32'h80000000);
      @(posedge clk); #1;
      check("b2b_sub", 32'h80000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
